// File: rtl/div60_by47_iter_if.sv
// Handshake bundle for the iterative constant divider:
// dividend offer in, quotient/remainder result out.
interface div60_by47_iter_if #(
  parameter int W  = 60,
  parameter int RW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_dividend;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_quotient;
  logic [RW-1:0] out_remainder;

  modport slave (
    input  in_valid, in_dividend, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder
  );

  modport master (
    output in_valid, in_dividend, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder
  );
endinterface

// File: rtl/div60_by47_iter.sv
// Iterative divide-by-constant: one CHUNK-bit digit per cycle,
// MSB first, carrying the remainder between digits.
module div60_by47_iter #(
  parameter int W     = 60,
  parameter int D     = 47,
  parameter int CHUNK = 4,
  parameter int RW    = 6
) (
  input  logic clk,
  input  logic rst,
  div60_by47_iter_if.slave bus,
  output logic busy
);
  localparam int NSTEP = W / CHUNK;
  localparam int CW    = $clog2(NSTEP);
  localparam int VW    = RW + CHUNK;
  localparam logic [VW-1:0] DV = VW'(D);
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [W-1:0]  q_q, q_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  qo_q, qo_d;
  logic [RW-1:0] ro_q, ro_d;

  logic [VW-1:0]    v, r;
  logic [CHUNK-1:0] qd;
  logic [RW-1:0]    rnew;

  // Restoring compare/subtract ladder; rem < D keeps qd within CHUNK bits.
  always_comb begin
    v  = {rem_q, sh_q[W-1 -: CHUNK]};
    r  = v;
    qd = '0;
    for (int k = CHUNK - 1; k >= 0; k--) begin
      if (r >= (DV << k)) begin
        r     = r - (DV << k);
        qd[k] = 1'b1;
      end
    end
    rnew = r[RW-1:0];
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    q_d     = q_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qo_d    = qo_q;
    ro_d    = ro_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sh_d    = bus.in_dividend;
          q_d     = '0;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sh_d  = sh_q << CHUNK;
        q_d   = {q_q[W-CHUNK-1:0], qd};
        rem_d = rnew;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          qo_d    = {q_q[W-CHUNK-1:0], qd};
          ro_d    = rnew;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qo_q    <= '0;
      ro_q    <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qo_q    <= qo_d;
      ro_q    <= ro_d;
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = (state_q == DONE);
  assign bus.out_quotient  = qo_q;
  assign bus.out_remainder = ro_q;
  assign busy              = (state_q != IDLE);
endmodule

// File: tb/tb_div60_by47_iter.sv
// Directed bench for div60_by47_iter: latency, divisor
// boundaries, backpressure, mid-run reset, short random run.
module tb_div60_by47_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   total  = 0;
  int   passed = 0;

  div60_by47_iter_if #(.W(60), .RW(6)) bus ();

  div60_by47_iter dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Offer n, wait for the result and compare; leaves the DUT in DONE.
  task automatic div_one(input string tag,
                         input logic [59:0] n,
                         input logic [59:0] eq,
                         input logic [5:0]  er,
                         input bit          chk_lat);
    int g;
    int lat;
    g = 0;
    bus.in_valid    = 1'b1;
    bus.in_dividend = n;
    while (!bus.in_ready && g < 50) begin
      tick();
      g++;
    end
    tick();
    bus.in_valid    = 1'b0;
    bus.in_dividend = {$urandom, $urandom};
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (chk_lat) chk({tag, "_lat"}, 64'(lat), 64'd15);
    chk({tag, "_q"}, 64'(bus.out_quotient), 64'(eq));
    chk({tag, "_r"}, 64'(bus.out_remainder), 64'(er));
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [59:0] n;
    logic [63:0] n64;
    logic [59:0] hq;
    logic [5:0]  hr;
    bit          stable;

    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.out_ready   = 1'b0;
    #12;
    chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_q",         64'(bus.out_quotient), 64'd0);
    chk("rst_r",         64'(bus.out_remainder), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    div_one("n1000", 60'd1000, 60'd21, 6'd13, 1'b1);
    chk("done_busy",     64'(busy), 64'd1);
    chk("done_in_ready", 64'(bus.in_ready), 64'd0);
    release_out();
    chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_in_ready",  64'(bus.in_ready), 64'd1);
    chk("idle_q_held",    64'(bus.out_quotient), 64'd21);

    div_one("n47", 60'd47, 60'd1, 6'd0, 1'b1);
    release_out();
    div_one("n46", 60'd46, 60'd0, 6'd46, 1'b0);
    release_out();
    div_one("n0", 60'd0, 60'd0, 6'd0, 1'b0);
    release_out();
    div_one("nmax", 60'hFFF_FFFF_FFFF_FFFF,
            60'd24530244778869084, 6'd27, 1'b1);
    chk("nmax_top", 64'(bus.out_quotient[59:55]), 64'd0);

    // Backpressure: hold result, offer a new dividend that must be ignored.
    hq = bus.out_quotient;
    hr = bus.out_remainder;
    bus.in_valid    = 1'b1;
    bus.in_dividend = 60'd123456;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.out_valid || bus.in_ready ||
          bus.out_quotient !== hq || bus.out_remainder !== hr)
        stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    bus.in_valid = 1'b0;
    release_out();
    chk("bp_in_ready",  64'(bus.in_ready), 64'd1);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd0);

    // Reset during RUN step 7 clears everything asynchronously.
    bus.in_valid    = 1'b1;
    bus.in_dividend = 60'd999999;
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_busy",      64'(busy), 64'd0);
    chk("arst_in_ready",  64'(bus.in_ready), 64'd1);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_q",         64'(bus.out_quotient), 64'd0);
    chk("arst_r",         64'(bus.out_remainder), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    div_one("n94", 60'd94, 60'd2, 6'd0, 1'b1);
    release_out();

    // Short random stream with stalls on both sides.
    for (int i = 0; i < 40; i++) begin
      n64 = {$urandom, $urandom};
      n = n64[59:0];
      if (i == 0) n = 60'd0 - 60'd1 - 60'd19;
      repeat ($urandom_range(0, 3)) tick();
      div_one("rnd", n, 60'(64'(n) / 64'd47), 6'(64'(n) % 64'd47), 1'b1);
      chk("rnd_rlt47", 64'(bus.out_remainder < 6'd47), 64'd1);
      repeat ($urandom_range(0, 3)) tick();
      release_out();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
